// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchronizer followed by a 4-state qualification FSM.
// Produces a registered debounced level plus one-cycle press and release strobes.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn,
    output logic       o_btn_level,
    output logic       o_press_pulse,
    output logic       o_release_pulse,
    output logic [1:0] o_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_PRESSED      = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    logic             sync1;
    logic             sync2;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;
    logic             level_nxt;

    // Any sample opposing the pending change restarts qualification from scratch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (sync2) begin
                    state_nxt = S_PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!sync2) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_PRESSED: begin
                if (!sync2) begin
                    state_nxt = S_RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (sync2) begin
                    state_nxt = S_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = S_IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Level follows the next state so it rises on the same edge as the press strobe.
    assign level_nxt = (state_nxt == S_PRESSED) || (state_nxt == S_RELEASE_WAIT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1           <= 1'b0;
            sync2           <= 1'b0;
            state           <= S_IDLE;
            cnt             <= '0;
            o_btn_level     <= 1'b0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
        end else begin
            sync1           <= i_btn;
            sync2           <= sync1;
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            o_btn_level     <= level_nxt;
            o_press_pulse   <= press_nxt;
            o_release_pulse <= release_nxt;
        end
    end

    assign o_state = state;

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1_000_000, giving the number of consecutive stable synchronized samples (minimum 2) required to accept an input change.
REQ-002 SHALL size its counter as CNT_W = $clog2(DEBOUNCE_CYCLES+1), derived locally; this is not a user parameter.
REQ-003 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_btn, input, 1 bit: the raw, asynchronous, bouncing push-button level.
REQ-006 SHALL have port o_btn_level, output, 1 bit: the debounced button level.
REQ-007 SHALL have port o_press_pulse, output, 1 bit: a one-cycle strobe on each accepted press; this is the clean count-enable for the downstream LED counter.
REQ-008 SHALL have port o_release_pulse, output, 1 bit: a one-cycle strobe on each accepted release.

Function
REQ-009 SHALL pass i_btn through a 2-flop synchronizer (sync1 -> sync2); only sync2 feeds the rest of the logic.
REQ-010 SHALL implement a 4-state FSM: S_IDLE (released and stable), S_PRESS_WAIT, S_PRESSED (pressed and stable), S_RELEASE_WAIT.
REQ-011 SHALL make these transitions: S_IDLE -> S_PRESS_WAIT when sync2=1, with the counter loaded to 1.
REQ-012 SHALL, in S_PRESS_WAIT, return to S_IDLE with counter cleared to 0 when sync2=0.
REQ-013 SHALL, in S_PRESS_WAIT with sync2=1 and counter < DEBOUNCE_CYCLES-1, increment the counter.
REQ-014 SHALL, in S_PRESS_WAIT with sync2=1 and counter = DEBOUNCE_CYCLES-1, go to S_PRESSED, clear the counter and assert o_press_pulse for the following cycle.
REQ-015 SHALL handle S_PRESSED and S_RELEASE_WAIT symmetrically to REQ-011..014 with sync2 polarity inverted; on acceptance it goes to S_IDLE and asserts o_release_pulse.
REQ-016 SHALL register o_btn_level, o_press_pulse and o_release_pulse.
REQ-017 SHALL drive o_btn_level to 1 exactly in S_PRESSED and S_RELEASE_WAIT.
REQ-018 SHALL give this latency: if i_btn goes high before rising edge N and stays high, sync2 is 1 after edge N+1, and o_btn_level and o_press_pulse rise after edge N+1+DEBOUNCE_CYCLES.
REQ-019 SHALL hold o_press_pulse high for exactly one cycle per accepted press, never two in a row, even if i_btn stays high indefinitely.
REQ-020 SHALL never assert o_press_pulse and o_release_pulse in the same cycle.
REQ-021 SHALL ignore, with no pulse or level change, a glitch of any width shorter than DEBOUNCE_CYCLES synchronized cycles, because each opposing sample restarts qualification.
REQ-022 SHALL NOT wrap the counter; it saturates by construction at DEBOUNCE_CYCLES-1.
REQ-023 SHALL send any undefined FSM encoding to S_IDLE on the next edge, with outputs 0.

Reset
REQ-024 SHALL, while i_reset=1 at a rising edge, force FSM=S_IDLE, counter=0, sync1=sync2=0, o_btn_level=0, o_press_pulse=0 and o_release_pulse=0.
REQ-025 SHALL let reset win over every other event, including a qualification that completes on the same edge; no pulse is emitted.
REQ-026 SHALL, when i_reset is asserted mid-press or mid-qualification, discard the press; after release of reset, a still-held button requires a full DEBOUNCE_CYCLES re-qualification and then yields exactly one o_press_pulse.

Verification (DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-027 SHALL check clean press: i_btn 0->1 before edge N and held -> o_btn_level=1 and o_press_pulse=1 after edge N+5, o_press_pulse=0 after edge N+6, and exactly one pulse in 50 cycles.
REQ-028 SHALL check bounce rejection: i_btn toggling 1,0,1,0 every 20 ns, then held high -> no pulse during bouncing, then exactly one o_press_pulse after 4 stable sync cycles.
REQ-029 SHALL check short glitch: i_btn high for 3 cycles then low -> o_btn_level stays 0 and no pulses.
REQ-030 SHALL check release: from S_PRESSED, i_btn 1->0 before edge M -> o_release_pulse=1 and o_btn_level=0 after edge M+5.
REQ-031 SHALL check reset mid-qualification: i_reset=1 for 1 cycle at counter=2 -> all outputs 0, and the held button pulses 6 edges after reset deasserts.
REQ-032 SHALL check a 20-press sequence with i_btn toggling every 100 ns -> exactly 20 o_press_pulse and 20 o_release_pulse, and never both high together.
